// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift/rotate mode encodings and the sequencer state type.
package alu_pkg;

  typedef enum logic [2:0] {
    MODE_SRL  = 3'b000,
    MODE_SLL  = 3'b001,
    MODE_SRA  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_RCR  = 3'b101,
    MODE_RCL  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rot_shift_step.sv
// One iteration of the rotate/shift unit: moves {carry,data} by k (0..STEP) bits for the given mode.
module rot_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int K_W   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  logic             sign,
  input  mode_t            mode,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] data_next,
  output logic             carry_next
);

  int               kk;
  logic [WIDTH:0]   lo;
  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   ring;
  logic [WIDTH:0]   rr;

  always_comb begin
    kk         = int'(k);
    // lo[0] / hi[WIDTH] hold the last bit pushed out on the right / left
    lo         = {data, carry} >> kk;
    hi         = {carry, data} << kk;
    ring       = {carry, data};
    rr         = ring;
    data_next  = data;
    carry_next = carry;
    if (kk != 0) begin
      case (mode)
        MODE_SRL: begin
          data_next  = lo[WIDTH:1];
          carry_next = lo[0];
        end
        MODE_SLL: begin
          data_next  = hi[WIDTH-1:0];
          carry_next = hi[WIDTH];
        end
        MODE_SRA: begin
          data_next  = lo[WIDTH:1] | (~({WIDTH{1'b1}} >> kk) & {WIDTH{sign}});
          carry_next = lo[0];
        end
        MODE_ROR: begin
          data_next  = (data >> kk) | (data << (WIDTH - kk));
          carry_next = data_next[WIDTH-1];
        end
        MODE_ROL: begin
          data_next  = (data << kk) | (data >> (WIDTH - kk));
          carry_next = data_next[0];
        end
        MODE_RCR: begin
          rr                      = (ring >> kk) | (ring << (WIDTH + 1 - kk));
          {carry_next, data_next} = rr;
        end
        MODE_RCL: begin
          rr                      = (ring << kk) | (ring >> (WIDTH + 1 - kk));
          {carry_next, data_next} = rr;
        end
        default: begin
          data_next  = data;
          carry_next = carry;
        end
      endcase
    end
  end

endmodule

// File: rtl/rot_shift_seq.sv
// Iterative multi-cycle rotate/shift unit with valid/ready on both sides; shifts up to STEP bits per cycle.
module rot_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int K_W = $clog2(STEP) + 1;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             carry_r;
  logic             sign_r;
  mode_t            mode_r;
  logic [AMT_W-1:0] remaining;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // k = min(STEP, remaining); the narrowing cast only happens when remaining < STEP
  always_comb begin
    k = (remaining >= AMT_W'(STEP)) ? K_W'(STEP) : K_W'(remaining);
  end

  rot_shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .K_W  (K_W)
  ) u_step (
    .data      (work),
    .carry     (carry_r),
    .sign      (sign_r),
    .mode      (mode_r),
    .k         (k),
    .data_next (step_data),
    .carry_next(step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      work      <= '0;
      carry_r   <= 1'b0;
      sign_r    <= 1'b0;
      mode_r    <= MODE_SRL;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work      <= in_a;
            carry_r   <= in_carry;
            sign_r    <= in_a[WIDTH-1];
            mode_r    <= mode_t'(in_mode);
            remaining <= in_amt;
            in_ready  <= 1'b0;
            if (in_amt != '0 && mode_t'(in_mode) != MODE_RSVD) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work      <= step_data;
          carry_r   <= step_carry;
          remaining <= remaining - AMT_W'(k);
          if (remaining == AMT_W'(k)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = work;
  assign out_carry = carry_r;

endmodule

// File: tb/tb_rot_shift_seq.sv
// Bench for rot_shift_seq: four instances (STEP 1,2,4,8) checked against an arithmetic reference model.
module tb_rot_shift_seq;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv[N];
  logic         ir[N];
  logic [W-1:0] ia[N];
  logic [4:0]   iamt[N];
  logic [2:0]   imode[N];
  logic         ic[N];
  logic         ov[N];
  logic         ordy[N];
  logic [W-1:0] od[N];
  logic         oc[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    rot_shift_seq #(.WIDTH(W), .STEP(1 << g)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .in_a     (ia[g]),
      .in_amt   (iamt[g]),
      .in_mode  (imode[g]),
      .in_carry (ic[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_data (od[g]),
      .out_carry(oc[g])
    );
  end

  int           tests = 0;
  int           fails = 0;
  logic         pending[N];
  logic [W-1:0] exp_d[N];
  logic         exp_c[N];

  // Reference: result {carry,data} straight from the mode definitions, whole amount at once
  function automatic logic [W:0] model(input logic [2:0] m, input logic [W-1:0] a,
                                       input logic [4:0] n, input logic c);
    logic [W-1:0] d;
    logic         co;
    logic [W:0]   r;
    logic [W:0]   rr;
    int           s;
    s = int'(n);
    r = {c, a};
    if (s == 0 || m == 3'b111) return {c, a};
    d  = a;
    co = c;
    case (m)
      3'b000: begin d = a >> s; co = a[s-1]; end
      3'b001: begin d = a << s; co = a[W-s]; end
      3'b010: begin d = W'($signed(a) >>> s); co = a[s-1]; end
      3'b011: begin d = (a >> s) | (a << (W - s)); co = d[W-1]; end
      3'b100: begin d = (a << s) | (a >> (W - s)); co = d[0]; end
      3'b101: begin rr = (r >> s) | (r << (W + 1 - s)); {co, d} = rr; end
      default: begin rr = (r << s) | (r >> (W + 1 - s)); {co, d} = rr; end
    endcase
    return {co, d};
  endfunction

  // Every cycle with a valid result: data/carry must match the model, in_ready must be low
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_n && ov[i]) begin
        tests++;
        if (!pending[i]) begin
          fails++;
          $display("FAIL spurious_valid dut%0d: out_valid=1 with no request outstanding", i);
        end else if (od[i] !== exp_d[i] || oc[i] !== exp_c[i] || ir[i] !== 1'b0) begin
          fails++;
          $display("FAIL result dut%0d: got data=%h carry=%b in_ready=%b, want data=%h carry=%b in_ready=0",
                   i, od[i], oc[i], ir[i], exp_d[i], exp_c[i]);
        end
      end
    end
  end

  task automatic run(input int i, input logic [2:0] m, input logic [W-1:0] a, input logic [4:0] n,
                     input logic c, input int hold, input logic lit, input logic [W-1:0] ld,
                     input logic lc, input int llat);
    logic [W:0] e;
    int         lat;
    int         t;
    e   = model(m, a, n, c);
    lat = (n == 0 || m == 3'b111) ? 1 : 1 + (int'(n) + (1 << i) - 1) / (1 << i);
    if (lit) lat = llat;
    @(negedge clk);
    t = 0;
    while (!ir[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ir[i]) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout dut%0d: in_ready=0, want 1", i);
      return;
    end
    ia[i] = a; iamt[i] = n; imode[i] = m; ic[i] = c; iv[i] = 1'b1;
    exp_d[i] = e[W-1:0];
    exp_c[i] = e[W];
    pending[i] = 1'b1;
    @(negedge clk);
    iv[i] = 1'b0;
    ia[i] = $urandom;
    iamt[i] = 5'($urandom);
    imode[i] = 3'($urandom);
    ic[i] = 1'($urandom);
    t = 1;
    while (!ov[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (!ov[i]) begin
      fails++;
      pending[i] = 1'b0;
      $display("FAIL valid_timeout dut%0d: no out_valid after %0d cycles", i, t);
      return;
    end
    if (t != lat) begin
      fails++;
      $display("FAIL latency dut%0d mode=%0d amt=%0d: got %0d cycles, want %0d", i, m, n, t, lat);
    end
    if (lit) begin
      tests++;
      if (od[i] !== ld || oc[i] !== lc) begin
        fails++;
        $display("FAIL literal dut%0d mode=%0d: got data=%h carry=%b, want data=%h carry=%b",
                 i, m, od[i], oc[i], ld, lc);
      end
    end
    repeat (hold) @(negedge clk);
    ordy[i] = 1'b1;
    @(posedge clk);
    #1;
    ordy[i] = 1'b0;
    pending[i] = 1'b0;
    tests++;
    if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
      fails++;
      $display("FAIL handshake_return dut%0d: out_valid=%b in_ready=%b, want 0 and 1", i, ov[i], ir[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; ia[i] = '0; iamt[i] = '0; imode[i] = '0; ic[i] = 1'b0;
      ordy[i] = 1'b0; pending[i] = 1'b0; exp_d[i] = '0; exp_c[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      tests++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || od[i] !== '0 || oc[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b data=%h carry=%b, want 1 0 0 0",
                 i, ir[i], ov[i], od[i], oc[i]);
      end
    end
    rst_n = 1'b1;

    run(0, 3'd3, 32'h00000001, 5'd1,  1'b0, 0, 1'b1, 32'h80000000, 1'b1, 2);
    run(2, 3'd2, 32'h80000010, 5'd5,  1'b0, 0, 1'b1, 32'hFC000000, 1'b1, 3);
    run(0, 3'd6, 32'h80000000, 5'd1,  1'b0, 0, 1'b1, 32'h00000000, 1'b1, 2);
    run(0, 3'd6, 32'h80000000, 5'd2,  1'b1, 0, 1'b1, 32'h00000003, 1'b0, 3);
    run(1, 3'd1, 32'hDEADBEEF, 5'd0,  1'b1, 0, 1'b1, 32'hDEADBEEF, 1'b1, 1);
    run(3, 3'd7, 32'hDEADBEEF, 5'd7,  1'b1, 0, 1'b1, 32'hDEADBEEF, 1'b1, 1);
    run(1, 3'd0, 32'h000000F0, 5'd4,  1'b0, 0, 1'b1, 32'h0000000F, 1'b0, 3);
    run(2, 3'd4, 32'h80000001, 5'd4,  1'b0, 0, 1'b1, 32'h00000018, 1'b0, 2);
    run(3, 3'd1, 32'h00000001, 5'd31, 1'b0, 0, 1'b1, 32'h80000000, 1'b0, 5);
    run(0, 3'd5, 32'h00000001, 5'd1,  1'b0, 0, 1'b1, 32'h00000000, 1'b1, 2);
    run(0, 3'd3, 32'h12345678, 5'd8,  1'b0, 5, 1'b1, 32'h78123456, 1'b0, 9);

    // Reset in the middle of a long SLL must discard it
    @(negedge clk);
    ia[0] = 32'hFFFFFFFF; iamt[0] = 5'd31; imode[0] = 3'd1; ic[0] = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== '0) begin
      fails++;
      $display("FAIL mid_shift_reset: out_valid=%b in_ready=%b data=%h, want 0 1 0", ov[0], ir[0], od[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 3'd1, 32'h0000000F, 5'd3, 1'b0, 1, 1'b1, 32'h00000078, 1'b0, 4);

    for (int s = 0; s < N; s++) begin
      if (s != 2) begin
        for (int j = 0; j < 30; j++) begin
          run(s, 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, '0, 1'b0, 0);
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
